// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: REQ -> LOAD -> EXEC loop with halt and branch handling.
// Optional fetch-timeout watchdog is built when FETCH_TIMEOUT_EN is defined.
module fetch_sequencer #(
    parameter int unsigned       ADDR_W         = 16,
    parameter logic [ADDR_W-1:0] RESET_PC       = '0,
    parameter int unsigned       TIMEOUT_CYCLES = 255
) (
    input  logic              clock,
    input  logic              reset,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ready,
    input  logic [15:0]       mem_data,
    output logic              IR_in_en,
    output logic [15:0]       instruction_in,
    output logic              ex_start,
    input  logic              ex_done,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              halt_req,
    output logic              halted,
    output logic [ADDR_W-1:0] pc,
    output logic              fetch_err
);

    typedef enum logic [2:0] {StIdle, StReq, StLoad, StExec, StHalt} state_e;

    state_e            r_state;
    state_e            w_state_next;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] w_pc_next;
    logic [15:0]       r_ir;
    logic [15:0]       w_ir_next;
    logic              r_ex_first;
    logic              w_timeout;

    if (TIMEOUT_CYCLES == 0) begin : g_param_check
        $error("TIMEOUT_CYCLES must be at least 1");
    end

`ifdef FETCH_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CntW-1:0] r_wait;
    logic            r_err;

    assign w_timeout = (r_state == StReq) && !mem_ready
                       && (r_wait == CntW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wait <= '0;
            r_err  <= 1'b0;
        end else begin
            // Counter is held at zero outside REQ so every REQ entry starts fresh.
            if (r_state != StReq) begin
                r_wait <= '0;
            end else if (!mem_ready) begin
                r_wait <= r_wait + 1'b1;
            end
            if (w_timeout) begin
                r_err <= 1'b1;
            end
        end
    end

    assign fetch_err = r_err;
`else
    assign w_timeout = 1'b0;
    assign fetch_err = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state    <= StIdle;
            r_pc       <= RESET_PC;
            r_ir       <= 16'h0000;
            r_ex_first <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_pc       <= w_pc_next;
            r_ir       <= w_ir_next;
            r_ex_first <= (r_state == StLoad);
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: w_state_next = halt_req ? StHalt : StReq;
            StReq: begin
                if (w_timeout) begin
                    w_state_next = StHalt;
                end else if (mem_ready) begin
                    w_state_next = StLoad;
                end
            end
            StLoad: w_state_next = StExec;
            StExec: begin
                if (ex_done) begin
                    w_state_next = halt_req ? StHalt : StReq;
                end
            end
            StHalt: begin
                // A latched fetch error parks the sequencer until reset.
                if (!halt_req && !fetch_err) begin
                    w_state_next = StReq;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_comb begin
        w_pc_next = r_pc;
        w_ir_next = r_ir;
        case (r_state)
            StReq: begin
                if (mem_ready) begin
                    w_ir_next = mem_data;
                end
            end
            StLoad: w_pc_next = r_pc + ADDR_W'(1);
            StExec: begin
                if (ex_done && branch_taken) begin
                    w_pc_next = branch_target;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        mem_req  = 1'b0;
        IR_in_en = 1'b0;
        ex_start = 1'b0;
        halted   = 1'b0;
        unique case (r_state)
            StReq:   mem_req  = 1'b1;
            StLoad:  IR_in_en = 1'b1;
            StExec:  ex_start = r_ex_first;
            StHalt:  halted   = 1'b1;
            default: ;
        endcase
    end

    assign mem_addr       = r_pc;
    assign pc             = r_pc;
    assign instruction_in = r_ir;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: stimulus pushes expected fetch addresses and
// instruction words; a negedge monitor pops and compares when the DUT presents them.
module tb_fetch_sequencer;

    localparam int unsigned AW = 16;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_ready = 1'b0;
    logic [15:0]   mem_data = 16'h0000;
    logic          IR_in_en;
    logic [15:0]   instruction_in;
    logic          ex_start;
    logic          ex_done = 1'b0;
    logic          branch_taken = 1'b0;
    logic [AW-1:0] branch_target = '0;
    logic          halt_req = 1'b0;
    logic          halted;
    logic [AW-1:0] pc;
    logic          fetch_err;

    fetch_sequencer #(
        .ADDR_W        (AW),
        .RESET_PC      (16'h0000),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_ready     (mem_ready),
        .mem_data      (mem_data),
        .IR_in_en      (IR_in_en),
        .instruction_in(instruction_in),
        .ex_start      (ex_start),
        .ex_done       (ex_done),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .halt_req      (halt_req),
        .halted        (halted),
        .pc            (pc),
        .fetch_err     (fetch_err)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int            n_pass = 0;
    int            n_chk = 0;
    logic [AW-1:0] q_addr[$];
    logic [15:0]   q_ir[$];
    logic [AW-1:0] m_pc = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Monitor: one expected address per REQ entry, one expected word per IR load.
    logic p_req = 1'b0;
    logic p_ir = 1'b0;
    always @(negedge clock) begin
        if (!reset) begin
            p_req <= 1'b0;
            p_ir  <= 1'b0;
        end else begin
            if (mem_req && !p_req) begin
                chk("addr_expected", 32'(q_addr.size() > 0), 1);
                if (q_addr.size() > 0) chk("fetch_addr", 32'(mem_addr), 32'(q_addr.pop_front()));
            end
            if (IR_in_en) begin
                chk("ir_expected", 32'(q_ir.size() > 0), 1);
                if (q_ir.size() > 0) chk("ir_word", 32'(instruction_in), 32'(q_ir.pop_front()));
                chk("ir_follows_req", 32'(p_req), 1);
            end
            if (p_ir) chk("ex_start_after_load", 32'(ex_start), 1);
            if (ex_start) chk("ex_start_first_only", 32'(p_ir), 1);
            if (mem_req || IR_in_en || ex_start)
                chk("strobes_exclusive", 32'(mem_req) + 32'(IR_in_en) + 32'(ex_start), 1);
            p_req <= mem_req;
            p_ir  <= IR_in_en;
        end
    end

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_pc"}, 32'(pc), 0);
        chk({tag, "_mem_addr"}, 32'(mem_addr), 0);
        chk({tag, "_strobes"}, {29'd0, mem_req, IR_in_en, ex_start}, 0);
        chk({tag, "_halted"}, 32'(halted), 0);
        chk({tag, "_fetch_err"}, 32'(fetch_err), 0);
        chk({tag, "_instr"}, 32'(instruction_in), 0);
    endtask

    // Called at a negedge with the DUT in (or about to enter) REQ.
    task automatic fetch(input int wt, input logic [15:0] data, input int ex_wt, input logic br,
                         input logic [AW-1:0] tgt, input logic hreq, input logic noise);
        int n = 0;
        q_ir.push_back(data);
        mem_ready = 1'b0;
        while (!mem_req && n < 20) begin
            @(negedge clock);
            n++;
        end
        chk("req_seen", 32'(mem_req), 1);
        halt_req = hreq;
        repeat (wt) @(negedge clock);
        mem_ready = 1'b1;
        mem_data  = data;
        @(negedge clock);
        mem_ready = 1'b0;
        mem_data  = 16'hDEAD;
        if (noise) begin
            ex_done       = 1'b1;
            branch_taken  = 1'b1;
            branch_target = 16'h1234;
        end
        @(negedge clock);
        ex_done      = 1'b0;
        branch_taken = 1'b0;
        repeat (ex_wt) @(negedge clock);
        ex_done       = 1'b1;
        branch_taken  = br;
        branch_target = tgt;
        if (noise) mem_ready = 1'b1;
        m_pc = br ? tgt : m_pc + 16'd1;
        q_addr.push_back(m_pc);
        @(negedge clock);
        ex_done      = 1'b0;
        branch_taken = 1'b0;
        mem_ready    = 1'b0;
        chk("pc_after_instr", 32'(pc), 32'(m_pc));
    endtask

    initial begin
        int t0;
        repeat (2) @(negedge clock);
        chk_reset_outputs("reset");
        q_addr.push_back(16'h0000);
        reset = 1'b1;
        #1 chk("no_req_at_release", 32'(mem_req), 0);
        @(negedge clock);
        chk("first_req", 32'(mem_req), 1);

        t0 = cyc;
        fetch(0, 16'hA5C3, 0, 1'b0, '0, 1'b0, 1'b0);
        chk("period_3", 32'(cyc - t0), 3);
        chk("req_after_period", 32'(mem_req), 1);

        fetch(2, 16'h1111, 1, 1'b0, '0, 1'b0, 1'b1);
        fetch(0, 16'h2222, 0, 1'b0, '0, 1'b0, 1'b0);
        fetch(1, 16'h3333, 2, 1'b0, '0, 1'b0, 1'b1);
        fetch(0, 16'h4444, 0, 1'b0, '0, 1'b0, 1'b0);
        chk("pc_is_5", 32'(pc), 5);
        fetch(0, 16'h5555, 0, 1'b1, 16'h0040, 1'b0, 1'b0);
        fetch(0, 16'h6666, 0, 1'b1, 16'hFFFF, 1'b0, 1'b0);
        fetch(0, 16'h7777, 1, 1'b0, '0, 1'b0, 1'b0);
        chk("pc_wrapped", 32'(pc), 0);

        // Halt requested during REQ: the fetch and execute still complete.
        fetch(1, 16'h8888, 0, 1'b0, '0, 1'b1, 1'b0);
        chk("halted_set", 32'(halted), 1);
        chk("halt_no_req", 32'(mem_req), 0);
        repeat (3) @(negedge clock);
        chk("halt_held", 32'(halted), 1);
        halt_req = 1'b0;
        @(negedge clock);
        chk("resume_req", 32'(mem_req), 1);
        chk("resume_halted", 32'(halted), 0);

        // Asynchronous reset in the middle of EXEC.
        q_ir.push_back(16'h9999);
        mem_ready = 1'b1;
        mem_data  = 16'h9999;
        @(negedge clock);
        mem_ready = 1'b0;
        @(negedge clock);
        chk("ex_start_pre_reset", 32'(ex_start), 1);
        #2 reset = 1'b0;
        #1 chk_reset_outputs("async_reset");
        m_pc = '0;
        q_addr.push_back(16'h0000);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        #1 chk("no_req_after_rerelease", 32'(mem_req), 0);
        @(negedge clock);
        chk("restart_req", 32'(mem_req), 1);
        fetch(0, 16'hABCD, 0, 1'b0, '0, 1'b0, 1'b0);

        // Memory never answers.
        mem_ready = 1'b0;
`ifdef FETCH_TIMEOUT_EN
        repeat (4) @(negedge clock);
        chk("timeout_err", 32'(fetch_err), 1);
        chk("timeout_halted", 32'(halted), 1);
        chk("timeout_pc", 32'(pc), 32'(m_pc));
        repeat (3) @(negedge clock);
        chk("timeout_stays_halted", {30'd0, halted, mem_req}, 32'h2);
`else
        repeat (20) @(negedge clock);
        chk("wait_forever_req", 32'(mem_req), 1);
        chk("wait_forever_err", 32'(fetch_err), 0);
        chk("wait_forever_pc", 32'(pc), 32'(m_pc));
`endif
        chk("ir_queue_drained", 32'(q_ir.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
